// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    UART_ARB_IDLE       = 2'd0,
    UART_ARB_LOAD       = 2'd1,
    UART_ARB_WAIT_START = 2'd2,
    UART_ARB_WAIT_DONE  = 2'd3
  } uart_arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned grant_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set request at or above ptr, wrapping modulo N.
module rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = grant_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  int unsigned      c;
  logic [IDX_W-1:0] ci;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    c     = 0;
    ci    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      ci = IDX_W'(c);
      if (req[ci]) begin
        found = 1'b1;
        idx   = ci;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Optional burst lock (REQ_LOCK input) is enabled by defining UART_ARB_BURST_LOCK_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned DATAWIDTH     = 3,
  parameter int unsigned START_TIMEOUT = 4
) (
  input  logic                                 CLK,
  input  logic                                 RST_SYN,
  input  logic [NUM_REQ-1:0]                   REQ_VALID,
  input  logic [NUM_REQ*(2**DATAWIDTH)-1:0]    REQ_DATA,
  input  logic [NUM_REQ-1:0]                   REQ_PAR_EN,
  input  logic [NUM_REQ-1:0]                   REQ_PAR_TYP,
`ifdef UART_ARB_BURST_LOCK_EN
  input  logic [NUM_REQ-1:0]                   REQ_LOCK,
`endif
  output logic [NUM_REQ-1:0]                   REQ_ACK,
  input  logic                                 TX_BUSY,
  output logic [(2**DATAWIDTH)-1:0]            TX_P_DATA,
  output logic                                 TX_DATA_VALID,
  output logic                                 TX_PAR_EN,
  output logic                                 TX_PAR_TYP,
  output logic [grant_width(NUM_REQ)-1:0]      GRANT_ID,
  output logic                                 ARB_BUSY,
  output logic                                 START_ERR
);

  localparam int unsigned W  = 2 ** DATAWIDTH;
  localparam int unsigned GW = grant_width(NUM_REQ);
  localparam int unsigned CW = $clog2(START_TIMEOUT + 1);

  uart_arb_state_t state_q, state_d;
  logic [GW-1:0]      rr_ptr_q, rr_ptr_d, grant_q, grant_d, next_ptr;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [W-1:0]       data_q, data_d;
  logic               par_en_q, par_en_d, par_typ_q, par_typ_d;
  logic               dv_q, dv_d, err_q, err_d, arb_busy_q;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               pick_found, keep_lock;
  logic [GW-1:0]      pick_idx;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (GW)
  ) u_pick (
    .req   (REQ_VALID),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign next_ptr = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);

`ifdef UART_ARB_BURST_LOCK_EN
  assign keep_lock = REQ_LOCK[grant_q] & REQ_VALID[grant_q];
`else
  assign keep_lock = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    dv_d      = 1'b0;
    err_d     = 1'b0;
    ack_d     = '0;
    unique case (state_q)
      UART_ARB_IDLE: begin
        if (pick_found && !TX_BUSY) begin
          grant_d         = pick_idx;
          data_d          = REQ_DATA[int'(pick_idx)*W +: W];
          par_en_d        = REQ_PAR_EN[pick_idx];
          par_typ_d       = REQ_PAR_TYP[pick_idx];
          dv_d            = 1'b1;
          ack_d[pick_idx] = 1'b1;
          state_d         = UART_ARB_LOAD;
        end
      end
      UART_ARB_LOAD: begin
        cnt_d   = '0;
        state_d = UART_ARB_WAIT_START;
      end
      UART_ARB_WAIT_START: begin
        if (TX_BUSY) begin
          state_d = UART_ARB_WAIT_DONE;
        end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
          // Byte was already acknowledged, so it is dropped rather than retried.
          cnt_d    = cnt_q + CW'(1);
          err_d    = 1'b1;
          rr_ptr_d = next_ptr;
          state_d  = UART_ARB_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      UART_ARB_WAIT_DONE: begin
        if (!TX_BUSY) begin
          rr_ptr_d = keep_lock ? grant_q : next_ptr;
          state_d  = UART_ARB_IDLE;
        end
      end
      default: state_d = UART_ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST_SYN) begin
      state_q    <= UART_ARB_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      dv_q       <= 1'b0;
      err_q      <= 1'b0;
      ack_q      <= '0;
      arb_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      dv_q       <= dv_d;
      err_q      <= err_d;
      ack_q      <= ack_d;
      arb_busy_q <= (state_d != UART_ARB_IDLE);
    end
  end

  assign REQ_ACK       = ack_q;
  assign TX_P_DATA     = data_q;
  assign TX_DATA_VALID = dv_q;
  assign TX_PAR_EN     = par_en_q;
  assign TX_PAR_TYP    = par_typ_q;
  assign GRANT_ID      = grant_q;
  assign ARB_BUSY      = arb_busy_q;
  assign START_ERR     = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple 11-cycle transmitter model.
module tb_uart_tx_arbiter;

  typedef struct {
    int         grant;
    logic [7:0] data;
    logic       pe;
    logic       pt;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST_SYN;
  logic [3:0]  REQ_VALID, REQ_PAR_EN, REQ_PAR_TYP, REQ_ACK;
  logic [31:0] REQ_DATA;
  logic        TX_BUSY, TX_DATA_VALID, TX_PAR_EN, TX_PAR_TYP, ARB_BUSY, START_ERR;
  logic [7:0]  TX_P_DATA;
  logic [1:0]  GRANT_ID;
`ifdef UART_ARB_BURST_LOCK_EN
  logic [3:0]  REQ_LOCK;
`endif

  logic [7:0] lane_data [4] = '{8'h3C, 8'h81, 8'hA5, 8'h7E};
  logic       lane_pe   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic       lane_pt   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  logic tx_en, ext_busy;
  int   frm;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  always #5 CLK = ~CLK;

  always_comb begin
    REQ_DATA    = '0;
    REQ_PAR_EN  = '0;
    REQ_PAR_TYP = '0;
    for (int i = 0; i < 4; i++) begin
      REQ_DATA[i*8 +: 8] = lane_data[i];
      REQ_PAR_EN[i]      = lane_pe[i];
      REQ_PAR_TYP[i]     = lane_pt[i];
    end
  end

  // Transmitter model: busy for 11 cycles starting the cycle after Data_Valid.
  always @(posedge CLK) begin
    if (RST_SYN) frm <= 0;
    else if (frm != 0) frm <= frm - 1;
    else if (tx_en && TX_DATA_VALID) frm <= 11;
  end
  assign TX_BUSY = (frm != 0) | ext_busy;

  uart_tx_arbiter #(
    .NUM_REQ       (4),
    .DATAWIDTH     (3),
    .START_TIMEOUT (4)
  ) dut (
    .CLK           (CLK),
    .RST_SYN       (RST_SYN),
    .REQ_VALID     (REQ_VALID),
    .REQ_DATA      (REQ_DATA),
    .REQ_PAR_EN    (REQ_PAR_EN),
    .REQ_PAR_TYP   (REQ_PAR_TYP),
`ifdef UART_ARB_BURST_LOCK_EN
    .REQ_LOCK      (REQ_LOCK),
`endif
    .REQ_ACK       (REQ_ACK),
    .TX_BUSY       (TX_BUSY),
    .TX_P_DATA     (TX_P_DATA),
    .TX_DATA_VALID (TX_DATA_VALID),
    .TX_PAR_EN     (TX_PAR_EN),
    .TX_PAR_TYP    (TX_PAR_TYP),
    .GRANT_ID      (GRANT_ID),
    .ARB_BUSY      (ARB_BUSY),
    .START_ERR     (START_ERR)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int g);
    exp_t e;
    e.grant = g;
    e.data  = lane_data[g];
    e.pe    = lane_pe[g];
    e.pt    = lane_pt[g];
    exp_q.push_back(e);
  endtask

  task automatic drive_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_dv();
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (TX_DATA_VALID) break;
    end
    check("dv_wait", {31'd0, TX_DATA_VALID}, 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (!ARB_BUSY) break;
    end
    check("idle_wait", {31'd0, ARB_BUSY}, 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_ack", {28'd0, REQ_ACK}, 32'd0);
    check("rst_dv", {31'd0, TX_DATA_VALID}, 32'd0);
    check("rst_err", {31'd0, START_ERR}, 32'd0);
    check("rst_data", {24'd0, TX_P_DATA}, 32'd0);
    check("rst_pe_pt", {30'd0, TX_PAR_EN, TX_PAR_TYP}, 32'd0);
    check("rst_grant", {30'd0, GRANT_ID}, 32'd0);
    check("rst_busy", {31'd0, ARB_BUSY}, 32'd0);
  endtask

  // Monitor: pop and compare on every Data_Valid; ACK must coincide with it.
  initial begin
    forever begin
      @(negedge CLK);
      check("ack_with_dv", {31'd0, (REQ_ACK != 0)}, {31'd0, TX_DATA_VALID});
      if (TX_DATA_VALID) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", {30'd0, GRANT_ID}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_grant", {30'd0, GRANT_ID}, e.grant);
          check("sb_data", {24'd0, TX_P_DATA}, {24'd0, e.data});
          check("sb_par", {30'd0, TX_PAR_EN, TX_PAR_TYP}, {30'd0, e.pe, e.pt});
          check("sb_ack", {28'd0, REQ_ACK}, 32'd1 << e.grant);
          check("sb_arb_busy", {31'd0, ARB_BUSY}, 32'd1);
        end
      end
    end
  end

  initial begin
    RST_SYN = 1'b1; REQ_VALID = '0; tx_en = 1'b1; ext_busy = 1'b0;
`ifdef UART_ARB_BURST_LOCK_EN
    REQ_LOCK = '0;
`endif
    repeat (2) drive_step();
    RST_SYN = 1'b0;
    @(negedge CLK);
    check_reset_outputs();

    // Single requester 2, two-cycle request-to-valid latency.
    drive_step();
    REQ_VALID = 4'b0100;
    push_exp(2);
    @(negedge CLK);
    check("lat_early", {31'd0, TX_DATA_VALID}, 32'd0);
    @(negedge CLK);
    check("lat_dv", {31'd0, TX_DATA_VALID}, 32'd1);
    drive_step();
    REQ_VALID = '0;
    wait_idle();

    // Fairness from a fresh reset: 0,1,2,3,0.
    drive_step();
    RST_SYN = 1'b1;
    drive_step();
    RST_SYN = 1'b0;
    REQ_VALID = 4'b1111;
    for (int g = 0; g < 5; g++) push_exp(g % 4);
    repeat (5) wait_dv();
    drive_step();
    REQ_VALID = '0;
    wait_idle();

    // Start timeout: rr_ptr is 1, so grant 1 then 2, each timing out.
    tx_en = 1'b0;
    REQ_VALID = 4'b0110;
    push_exp(1);
    push_exp(2);
    wait_dv();
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      check("start_err", {31'd0, START_ERR}, (k == 5) ? 32'd1 : 32'd0);
    end
    wait_dv();
    drive_step();
    REQ_VALID = '0;
    wait_idle();
    tx_en = 1'b1;

    // Reset during WAIT_DONE; rr_ptr must restart at 0 (else 3 would win).
    REQ_VALID = 4'b0010;
    push_exp(1);
    wait_dv();
    drive_step();
    REQ_VALID = '0;
    repeat (2) @(negedge CLK);
    drive_step();
    RST_SYN = 1'b1;
    drive_step();
    RST_SYN = 1'b0;
    @(negedge CLK);
    check_reset_outputs();
    REQ_VALID = 4'b1001;
    push_exp(0);
    wait_dv();
    drive_step();
    REQ_VALID = '0;
    wait_idle();

    // External busy blocks the grant; grant follows two cycles after it drops.
    ext_busy = 1'b1;
    REQ_VALID = 4'b0100;
    push_exp(2);
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      check("busy_hold", {31'd0, TX_DATA_VALID}, 32'd0);
    end
    drive_step();
    ext_busy = 1'b0;
    @(negedge CLK);
    check("busy_release_early", {31'd0, TX_DATA_VALID}, 32'd0);
    @(negedge CLK);
    check("busy_release_dv", {31'd0, TX_DATA_VALID}, 32'd1);
    drive_step();
    REQ_VALID = '0;
    wait_idle();

`ifdef UART_ARB_BURST_LOCK_EN
    // Move rr_ptr to 1, then requester 1 locks for three bytes.
    REQ_VALID = 4'b0001;
    push_exp(0);
    wait_dv();
    drive_step();
    REQ_VALID = '0;
    wait_idle();
    REQ_VALID = 4'b1011;
    REQ_LOCK  = 4'b0010;
    push_exp(1); push_exp(1); push_exp(1); push_exp(3); push_exp(0);
    repeat (3) wait_dv();
    drive_step();
    REQ_VALID = 4'b1001;
    repeat (2) wait_dv();
    drive_step();
    REQ_VALID = '0;
    REQ_LOCK  = '0;
    wait_idle();
`endif

    repeat (4) @(negedge CLK);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
